// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_AE_THRESH = 2;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one read port.
// The read port is registered by default, combinational under FIFO_FWFT_EN.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = ^{re, reset};
  assign rdata     = mem[raddr];
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO: pointers, occupancy, registered flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read behaviour.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc_c;
  logic          rd_acc_c;
  logic [CW-1:0] count_nxt_c;

  // Acceptance uses the pre-edge flags only.
  assign wr_acc_c = wr_en & ~full;
  assign rd_acc_c = rd_en & ~empty;

  always_comb begin
    count_nxt_c = count;
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_nxt_c = count + CW'(1);
      2'b01:   count_nxt_c = count - CW'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc_c) rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt_c;
      full         <= (count_nxt_c == CW'(DEPTH));
      empty        <= (count_nxt_c == '0);
      almost_full  <= (count_nxt_c >= CW'(AF_THRESH));
      almost_empty <= (count_nxt_c <= CW'(AE_THRESH));
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

`ifdef FIFO_FWFT_EN
  assign dout_valid = ~empty;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout_valid <= 1'b0;
    else        dout_valid <= rd_acc_c;
  end
`endif

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc_c),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc_c),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: directed corner sequences plus biased random traffic
// checked against a queue-based occupancy/data model.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  localparam int unsigned WIDTH = DEF_WIDTH;
  localparam int unsigned DEPTH = DEF_DEPTH;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = DEF_AE_THRESH;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  param_sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_dv;
  logic             exp_ovf;
  logic             exp_udf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",        64'(count),        64'(n));
    check("full",         64'(full),         64'(n == DEPTH));
    check("empty",        64'(empty),        64'(n == 0));
    check("almost_full",  64'(almost_full),  64'(n >= AF));
    check("almost_empty", 64'(almost_empty), 64'(n <= AE));
    check("overflow",     64'(overflow),     64'(exp_ovf));
    check("underflow",    64'(underflow),    64'(exp_udf));
`ifdef FIFO_FWFT_EN
    check("dout_valid",   64'(dout_valid),   64'(n != 0));
    if (n != 0) check("dout", 64'(dout), 64'(q[0]));
`else
    check("dout_valid",   64'(dout_valid),   64'(exp_dv));
    check("dout",         64'(dout),         64'(exp_dout));
`endif
  endtask

  // One clock of stimulus; the model sees the pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    int  n;
    logic acc_w, acc_r;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    n       = q.size();
    exp_ovf = w && (n == DEPTH);
    exp_udf = r && (n == 0);
    acc_w   = w && (n < DEPTH);
    acc_r   = r && (n > 0);
    exp_dv  = acc_r;
    if (acc_r) exp_dout = q.pop_front();
    if (acc_w) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b0;
    #1;
    q.delete();
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    check_all();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    #20;
    check_all();
    reset = 1'b1;

    // Fill with FF..F0, then one write that must be dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, WIDTH'(8'hFF - i));
    step(1'b1, 1'b0, 8'h11);
    // Drain in order plus one read into an empty FIFO.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, '0);

    // Simultaneous read/write at 15 entries and when full.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, WIDTH'($urandom));
    step(1'b1, 1'b1, WIDTH'($urandom));
    step(1'b1, 1'b0, WIDTH'($urandom));
    step(1'b1, 1'b1, WIDTH'($urandom));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);

    // Simultaneous read/write while empty: write lands, read dropped.
    step(1'b1, 1'b1, 8'h5A);
    step(1'b0, 1'b1, '0);

    // Reset in the middle of traffic discards contents.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'($urandom));
    do_reset();
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Biased random traffic alternating between fill-heavy and drain-heavy phases.
    for (int ph = 0; ph < 8; ph++) begin
      int pw;
      pw = (ph % 2 == 0) ? 75 : 25;
      if (ph == 5) do_reset();
      for (int k = 0; k < 200; k++) begin
        logic w, r;
        w = ($urandom_range(99) < 32'(pw));
        r = ($urandom_range(99) < 32'(100 - pw));
        step(w, r, WIDTH'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
